move_scheduler: RTL

Sequences every movement of the active falling piece: gravity steps, player shifts with auto-repeat, rotations and soft drop. It arbitrates these requesters onto the single board collision-check port, one request at a time. It sits between the keyboard/frame-tick sources and the board datapath. It produces the one-cycle `hitbottom` pulse consumed by the game-state FSM.

---
 rtl/tetris_pkg.sv | 49 ++++
 rtl/move_scheduler_key_repeat.sv | 90 +++++++++
 rtl/move_scheduler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared types and constants for the falling-piece movement logic.
package tetris_pkg;

  localparam int unsigned KEY_W   = 8;
  localparam int unsigned LEVEL_W = 4;
  localparam int unsigned GRAV_W  = 6;

  // Board move request kinds; encoding is shared with the board datapath.
  typedef enum logic [1:0] {
    MV_DOWN  = 2'd0,
    MV_LEFT  = 2'd1,
    MV_RIGHT = 2'd2,
    MV_ROT   = 2'd3
  } move_kind_t;

  // Movement scheduler states.
  typedef enum logic [1:0] {
    ST_WAIT_SPAWN = 2'd0,
    ST_READY      = 2'd1,
    ST_ISSUE      = 2'd2,
    ST_LANDED     = 2'd3
  } sched_state_t;

  localparam logic [KEY_W-1:0] KEY_RIGHT = 8'h4F;
  localparam logic [KEY_W-1:0] KEY_LEFT  = 8'h50;
  localparam logic [KEY_W-1:0] KEY_DOWN  = 8'h51;
  localparam logic [KEY_W-1:0] KEY_UP    = 8'h52;

  // True for the two keys that produce horizontal shifts.
  function automatic logic is_shift_key(input logic [KEY_W-1:0] key);
    return (key == KEY_LEFT) || (key == KEY_RIGHT);
  endfunction

  // Gravity period in frames; the subtraction is clamped before it can wrap.
  function automatic logic [GRAV_W-1:0] grav_period(
    input logic [LEVEL_W-1:0] lvl,
    input int unsigned        base_frames,
    input int unsigned        step_frames,
    input int unsigned        min_frames
  );
    int unsigned prod;
    prod = step_frames * 32'(lvl);
    if (prod >= (base_frames - min_frames)) begin
      return GRAV_W'(min_frames);
    end
    return GRAV_W'(base_frames - prod);
  endfunction

endpackage

// File: rtl/move_scheduler_key_repeat.sv
// Shift-key edge detection with delayed auto-shift and auto-repeat.
module key_repeat
  import tetris_pkg::*;
#(
  parameter int unsigned DAS_FRAMES = 10,
  parameter int unsigned ARR_FRAMES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic             i_frame_tick,
  input  logic [KEY_W-1:0] i_keycode,
  output logic [KEY_W-1:0] o_prev_key,
  output logic             o_shift_evt_c,
  output logic             o_shift_dir_c
);

  localparam int unsigned RPT_MAX = (DAS_FRAMES > ARR_FRAMES) ? DAS_FRAMES : ARR_FRAMES;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic [KEY_W-1:0] r_prev_key;
  logic [RPT_W-1:0] r_rpt_cnt;
  logic [RPT_W-1:0] w_rpt_cnt_nxt;
  logic             r_active;
  logic             w_active_nxt;
  logic             r_dir;
  logic             w_dir_nxt;
  logic             w_evt;
  logic             w_edge;
  logic             w_held;

  assign w_edge = (i_keycode != r_prev_key);
  // The repeat only continues while the key that started it is still down.
  assign w_held = r_active && (i_keycode == (r_dir ? KEY_RIGHT : KEY_LEFT));

  // Edge, DAS and ARR decisions; clear wins, disabled means frozen.
  always_comb begin
    w_rpt_cnt_nxt = r_rpt_cnt;
    w_active_nxt  = r_active;
    w_dir_nxt     = r_dir;
    w_evt         = 1'b0;
    if (i_clear) begin
      w_rpt_cnt_nxt = '0;
      w_active_nxt  = 1'b0;
    end else if (i_enable) begin
      if (w_edge) begin
        if (is_shift_key(i_keycode)) begin
          w_evt         = 1'b1;
          w_dir_nxt     = (i_keycode == KEY_RIGHT);
          w_rpt_cnt_nxt = RPT_W'(DAS_FRAMES);
          w_active_nxt  = 1'b1;
        end else begin
          w_rpt_cnt_nxt = '0;
          w_active_nxt  = 1'b0;
        end
      end else if (!w_held) begin
        w_rpt_cnt_nxt = '0;
        w_active_nxt  = 1'b0;
      end else if (i_frame_tick) begin
        if (r_rpt_cnt <= RPT_W'(1)) begin
          w_evt         = 1'b1;
          w_rpt_cnt_nxt = RPT_W'(ARR_FRAMES);
        end else begin
          w_rpt_cnt_nxt = r_rpt_cnt - RPT_W'(1);
        end
      end
    end
  end

  // Previous keycode always tracks so a pause never manufactures an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_key <= '0;
      r_rpt_cnt  <= '0;
      r_active   <= 1'b0;
      r_dir      <= 1'b0;
    end else begin
      r_prev_key <= i_keycode;
      r_rpt_cnt  <= w_rpt_cnt_nxt;
      r_active   <= w_active_nxt;
      r_dir      <= w_dir_nxt;
    end
  end

  assign o_prev_key    = r_prev_key;
  assign o_shift_evt_c = w_evt;
  assign o_shift_dir_c = w_dir_nxt;

endmodule

// File: rtl/move_scheduler.sv
// Arbitrates gravity, rotate and shift movements onto the board check port.
module move_scheduler
  import tetris_pkg::*;
#(
  parameter int unsigned BASE_FRAMES = 48,
  parameter int unsigned STEP_FRAMES = 4,
  parameter int unsigned MIN_FRAMES  = 2,
  parameter int unsigned DAS_FRAMES  = 10,
  parameter int unsigned ARR_FRAMES  = 3
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_tick,
  input  logic [KEY_W-1:0]   keycode,
  input  logic [LEVEL_W-1:0] level,
  input  logic               Pause,
  input  logic               resetBlocks,
  output logic               move_req,
  output logic [1:0]         move_kind,
  input  logic               move_ack,
  input  logic               move_ok,
  output logic               hitbottom
);

  sched_state_t      r_state;
  sched_state_t      w_state_nxt;
  move_kind_t        r_kind;
  move_kind_t        w_kind_nxt;
  logic              r_move_req;
  logic              r_hitbottom;
  logic              r_discard;
  logic              w_discard_nxt;

  logic              r_grav_pend;
  logic              r_rot_pend;
  logic              r_shift_pend;
  logic              r_shift_dir;
  logic              w_take_grav;
  logic              w_take_rot;
  logic              w_take_shift;

  logic [GRAV_W-1:0] r_grav_cnt;
  logic [GRAV_W-1:0] w_grav_period;
  logic [GRAV_W:0]   w_grav_cnt_inc;

  logic              w_live;
  logic              w_clear;
  logic              w_run;
  logic              w_grav_evt;
  logic              w_rot_evt;
  logic              w_shift_evt;
  logic              w_shift_dir;
  logic              w_shift_keep;
  logic [KEY_W-1:0]  w_prev_key;

  // Scheduling runs only between spawn and landing; resetBlocks wipes it.
  assign w_live  = (r_state == ST_READY) || (r_state == ST_ISSUE);
  assign w_clear = resetBlocks || !w_live;
  assign w_run   = !Pause;

  assign w_grav_period  = (keycode == KEY_DOWN) ? GRAV_W'(MIN_FRAMES)
                        : grav_period(level, BASE_FRAMES, STEP_FRAMES, MIN_FRAMES);
  assign w_grav_cnt_inc = {1'b0, r_grav_cnt} + (GRAV_W + 1)'(1);
  // >= so a freshly held down key never has to wait for a counter wrap.
  assign w_grav_evt     = !w_clear && w_run && frame_tick
                        && (w_grav_cnt_inc >= {1'b0, w_grav_period});
  assign w_rot_evt      = !w_clear && w_run && (keycode == KEY_UP) && (w_prev_key != KEY_UP);
  assign w_shift_keep   = r_shift_pend && !w_take_shift;

  key_repeat #(
    .DAS_FRAMES (DAS_FRAMES),
    .ARR_FRAMES (ARR_FRAMES)
  ) u_key_repeat (
    .clk           (Clk),
    .rst_n         (Reset_n),
    .i_enable      (w_run),
    .i_clear       (w_clear),
    .i_frame_tick  (frame_tick),
    .i_keycode     (keycode),
    .o_prev_key    (w_prev_key),
    .o_shift_evt_c (w_shift_evt),
    .o_shift_dir_c (w_shift_dir)
  );

  // Gravity frame counter; frozen while paused.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_grav_cnt <= '0;
    end else if (w_clear) begin
      r_grav_cnt <= '0;
    end else if (w_run && frame_tick) begin
      r_grav_cnt <= w_grav_evt ? '0 : w_grav_cnt_inc[GRAV_W-1:0];
    end
  end

  // Single-bit pending flags; a new event beats a same-cycle consume.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_grav_pend  <= 1'b0;
      r_rot_pend   <= 1'b0;
      r_shift_pend <= 1'b0;
      r_shift_dir  <= 1'b0;
    end else if (w_clear) begin
      r_grav_pend  <= 1'b0;
      r_rot_pend   <= 1'b0;
      r_shift_pend <= 1'b0;
    end else begin
      r_grav_pend  <= (r_grav_pend && !w_take_grav) || w_grav_evt;
      r_rot_pend   <= (r_rot_pend && !w_take_rot) || w_rot_evt;
      r_shift_pend <= w_shift_keep || w_shift_evt;
      if (w_shift_evt && !w_shift_keep) begin
        r_shift_dir <= w_shift_dir;
      end
    end
  end

  // Next-state and move selection.
  always_comb begin
    w_state_nxt   = r_state;
    w_kind_nxt    = r_kind;
    w_discard_nxt = r_discard;
    w_take_grav   = 1'b0;
    w_take_rot    = 1'b0;
    w_take_shift  = 1'b0;
    case (r_state)
      ST_WAIT_SPAWN: begin
        if (resetBlocks) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (!resetBlocks && !Pause) begin
          if (r_grav_pend) begin
            w_kind_nxt  = MV_DOWN;
            w_take_grav = 1'b1;
            w_state_nxt = ST_ISSUE;
          end else if (r_rot_pend) begin
            w_kind_nxt  = MV_ROT;
            w_take_rot  = 1'b1;
            w_state_nxt = ST_ISSUE;
          end else if (r_shift_pend) begin
            w_kind_nxt   = r_shift_dir ? MV_RIGHT : MV_LEFT;
            w_take_shift = 1'b1;
            w_state_nxt  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (move_ack) begin
          w_discard_nxt = 1'b0;
          if (r_discard || resetBlocks) begin
            w_state_nxt = ST_READY;
          end else if ((r_kind == MV_DOWN) && !move_ok) begin
            w_state_nxt = ST_LANDED;
          end else begin
            w_state_nxt = ST_READY;
          end
        end else if (resetBlocks) begin
          w_discard_nxt = 1'b1;
        end
      end
      ST_LANDED: begin
        w_state_nxt = resetBlocks ? ST_READY : ST_WAIT_SPAWN;
      end
      default: begin
        w_state_nxt = ST_WAIT_SPAWN;
      end
    endcase
  end

  // State register with registered request/landing outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= ST_WAIT_SPAWN;
      r_kind      <= MV_DOWN;
      r_discard   <= 1'b0;
      r_move_req  <= 1'b0;
      r_hitbottom <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_kind      <= w_kind_nxt;
      r_discard   <= w_discard_nxt;
      r_move_req  <= (w_state_nxt == ST_ISSUE);
      r_hitbottom <= (w_state_nxt == ST_LANDED);
    end
  end

  assign move_req  = r_move_req;
  assign move_kind = r_kind;
  assign hitbottom = r_hitbottom;

endmodule
